// File: rtl/posit_encode_pipe_pkg.sv
// Shared posit constants and the unpacked-result payload exchanged between
// the decode front end, the arithmetic cores and the encoder.
package posit_encode_pipe_pkg;

    localparam int unsigned POSIT_N  = 32;
    localparam int unsigned POSIT_ES = 2;

    // Signed scale width large enough for every regime/exponent combination.
    function automatic int unsigned scale_width(input int unsigned n, input int unsigned es);
        return $clog2(n) + es + 2;
    endfunction

    localparam int unsigned POSIT_SW = scale_width(POSIT_N, POSIT_ES);
    localparam int unsigned POSIT_FW = POSIT_N;

    localparam logic [POSIT_N-1:0] MAXPOS = {1'b0, {(POSIT_N-1){1'b1}}};
    localparam logic [POSIT_N-1:0] MINPOS = POSIT_N'(1);
    localparam logic [POSIT_N-1:0] NAR    = {1'b1, {(POSIT_N-1){1'b0}}};

    typedef struct packed {
        logic                       sign;
        logic signed [POSIT_SW-1:0] scale;
        logic [POSIT_FW-1:0]        frac;
        logic                       sticky;
        logic                       zero;
        logic                       nar;
    } posit_unpacked_t;

endpackage

// File: rtl/posit_round_rne.sv
// Round-to-nearest-even of a truncated posit magnitude, clamped so that it
// neither overflows into NaR nor underflows to zero, then sign-applied.
module posit_round_rne
    import posit_encode_pipe_pkg::*;
#(
    parameter int unsigned N = POSIT_N
) (
    input  logic         sign,
    input  logic         zero,
    input  logic         nar,
    input  logic [N-2:0] mag,
    input  logic         guard,
    input  logic         sticky,
    output logic [N-1:0] data_c
);

    logic         round_up;
    logic [N-2:0] mag_r;
    logic [N-1:0] pos;

    always_comb begin
        round_up = guard && (sticky || mag[0]) && !(&mag);
        mag_r    = mag + (N-1)'(round_up);
        if (mag_r == '0) begin
            mag_r = (N-1)'(1);
        end
        pos = {1'b0, mag_r};
        if (nar) begin
            data_c = {1'b1, {(N-1){1'b0}}};
        end else if (zero) begin
            data_c = '0;
        end else if (sign) begin
            data_c = -pos;
        end else begin
            data_c = pos;
        end
    end

endmodule

// File: rtl/posit_encode_pipe.sv
// Two-stage posit encoder: stage 1 builds the left-justified regime/exponent/
// fraction field, stage 2 rounds and packs; one global advance for both stages.
module posit_encode_pipe
    import posit_encode_pipe_pkg::*;
#(
    parameter int unsigned N  = POSIT_N,
    parameter int unsigned ES = POSIT_ES,
    parameter int unsigned SW = scale_width(N, ES),
    parameter int unsigned FW = N
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sign,
    input  logic [SW-1:0] in_scale,
    input  logic [FW-1:0] in_frac,
    input  logic          in_sticky,
    input  logic          in_zero,
    input  logic          in_nar,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data
);

    localparam int unsigned MW = N - 1;
    localparam int unsigned W  = MW + FW + ES + 2;

    logic          adv;
    logic [SW-1:0] k;
    logic [ES-1:0] e;
    logic [SW-1:0] rlen;
    logic          sat_hi;
    logic          sat_lo;
    logic [W-1:0]  regime;
    logic [W-1:0]  tail;
    logic [W-1:0]  field;
    logic [N-1:0]  round_c;

    logic          s1_valid_q,  s1_valid_d;
    logic          s1_sign_q,   s1_sign_d;
    logic          s1_zero_q,   s1_zero_d;
    logic          s1_nar_q,    s1_nar_d;
    logic [MW-1:0] s1_mag_q,    s1_mag_d;
    logic          s1_guard_q,  s1_guard_d;
    logic          s1_sticky_q, s1_sticky_d;
    logic          out_valid_q, out_valid_d;
    logic [N-1:0]  out_data_q,  out_data_d;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Regime run length is k+2 for k >= 0 and -k+1 for k < 0 (~k == -k-1).
    always_comb begin
        k      = SW'($signed(in_scale) >>> ES);
        e      = in_scale[ES-1:0];
        sat_hi = $signed(k) >= $signed(SW'(N-2));
        sat_lo = $signed(k) <= -$signed(SW'(N-1));
        rlen   = k[SW-1] ? (~k + SW'(2)) : (k + SW'(2));
        regime = k[SW-1] ? (W'(1) << (W - 32'(rlen)))
                         : ~({W{1'b1}} >> (32'(rlen) - 1));
        tail   = W'({e, in_frac}) << (W - ES - FW - 32'(rlen));
        field  = regime | tail;
    end

    posit_round_rne #(.N(N)) u_round (
        .sign   (s1_sign_q),
        .zero   (s1_zero_q),
        .nar    (s1_nar_q),
        .mag    (s1_mag_q),
        .guard  (s1_guard_q),
        .sticky (s1_sticky_q),
        .data_c (round_c)
    );

    // Both stages move together; saturated beats carry a clean magnitude so
    // stage 2 never rounds them.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sign_d   = s1_sign_q;
        s1_zero_d   = s1_zero_q;
        s1_nar_d    = s1_nar_q;
        s1_mag_d    = s1_mag_q;
        s1_guard_d  = s1_guard_q;
        s1_sticky_d = s1_sticky_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (adv) begin
            s1_valid_d  = in_valid;
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = round_c;
            end
            if (in_valid) begin
                s1_sign_d = in_sign;
                s1_zero_d = in_zero;
                s1_nar_d  = in_nar;
                if (sat_hi) begin
                    s1_mag_d    = {MW{1'b1}};
                    s1_guard_d  = 1'b0;
                    s1_sticky_d = 1'b0;
                end else if (sat_lo) begin
                    s1_mag_d    = MW'(1);
                    s1_guard_d  = 1'b0;
                    s1_sticky_d = 1'b0;
                end else begin
                    s1_mag_d    = field[W-1 -: MW];
                    s1_guard_d  = field[W-MW-1];
                    s1_sticky_d = (|field[W-MW-2:0]) | in_sticky;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_nar_q    <= 1'b0;
            s1_mag_q    <= '0;
            s1_guard_q  <= 1'b0;
            s1_sticky_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_zero_q   <= s1_zero_d;
            s1_nar_q    <= s1_nar_d;
            s1_mag_q    <= s1_mag_d;
            s1_guard_q  <= s1_guard_d;
            s1_sticky_q <= s1_sticky_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: doc/posit_encode_pipe.md
Name: posit_encode_pipe

Overview:
- Output-side encoder for the posit arithmetic datapath: the inverse of the posit decode front end used by the adder/subtractor.
- Accepts an unpacked result (sign, scale, MSB-aligned fraction, sticky, zero/NaR flags) and produces a rounded, saturated N-bit posit.
- Two-stage pipeline with valid/ready handshake, so the adder core and future mul/div units can share one registered encode stage.

Parameters:
- N, 32, posit width in bits.
- ES, 2, exponent field width.
- SW, $clog2(N)+ES+2 (default 9), signed scale width.
- FW, N, fraction input width, MSB-aligned, hidden bit excluded.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  encoder can accept the beat this cycle.
- in_sign  in  1  result sign.
- in_scale  in  SW  signed scale, value = 2^scale * 1.frac.
- in_frac  in  FW  fraction bits below the hidden 1.
- in_sticky  in  1  OR of all fraction bits discarded upstream.
- in_zero  in  1  result is exactly zero.
- in_nar  in  1  result is NaR; has priority over in_zero.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  N  encoded posit, two's complement for negative values.

Behaviour:
- Reset: one clock and a synchronous active-high reset. On rst high at a clock edge, both stage valids clear, out_valid=0, out_data=0 and in_ready=1 after that edge. Reset mid-flight discards all in-flight beats silently.
- Handshake: a transfer occurs when valid and ready are both high at a clock edge. Global advance is adv = !out_valid || out_ready; in_ready = adv.
  - When adv=0, both stages hold their contents.
  - Data must never change while out_valid=1 and out_ready=0.
- Latency: 2 cycles from input transfer to out_valid. Full throughput is one beat per cycle with out_ready held high.
- Stage 1 (regime build):
  - k = scale >>> ES (arithmetic, floor); e = scale[ES-1:0].
  - Saturation: k >= N-2 forces magnitude maxpos = {1'b0,{N-1{1'b1}}}. k <= -(N-1) forces magnitude minpos = 1. Saturated beats skip rounding.
  - Regime for k >= 0: k+1 ones then a 0. For k < 0: -k zeros then a 1.
  - Concatenate regime, e and frac, then left-justify into an (N-1)+FW+ES+2 bit field.
  - Register the sign, the special flags, the top N-1 bits, the guard bit, and sticky = OR(remaining bits, in_sticky).
- Stage 2 (round/pack):
  - Round to nearest, ties to even: round up when guard && (sticky || lsb).
  - Round-up is suppressed when the unrounded magnitude equals maxpos, so the result never becomes NaR.
  - Magnitude 0 after truncation is forced to minpos, so a nonzero value never rounds to zero.
  - Output is -magnitude when sign=1.
  - in_nar gives out_data = 1 followed by N-1 zeros (0x80000000). in_zero gives 0. Special beats ignore all other fields.

Decomposition:
- posit_pkg: N/ES default constants, function clog2-based SW derivation, localparams MAXPOS/MINPOS/NAR, and a struct typedef posit_unpacked_t {sign, scale, frac, sticky, zero, nar} shared with the decoder.
- One natural sub-module, posit_round_rne: stage-2 combinational rounding and negation, reusable by other arithmetic units.

Test Plan:
- sign=0, scale=0, frac=0 -> 0x40000000; sign=1 same -> 0xC0000000; scale=1 -> 0x48000000; scale=-1 -> 0x38000000. Each appears exactly 2 cycles after the input transfer.
- Rounding, scale=0: frac=0x00000010 (tie, lsb=0) -> 0x40000000. frac=0x00000030 (tie, lsb=1) -> 0x40000002. frac=0x00000010 with sticky=1 -> 0x40000001.
- Saturation: scale=200 -> 0x7FFFFFFF. scale=-200 -> 0x00000001. scale=119, frac all ones, sticky=1 -> 0x7FFFFFFF, not 0x80000000.
- Specials: zero=1 -> 0x00000000. nar=1 with zero=1 -> 0x80000000.
- Backpressure: stream 8 beats with in_valid=1 while out_ready toggles 1,0,0,1. Required: in_ready low when the output is stalled and full, out_data stable while stalled, all 8 results in order with none lost or duplicated.
- Reset: assert rst for 1 cycle with 2 beats in flight -> out_valid=0 and out_data=0 next cycle, those beats never appear, and the next accepted beat emerges after 2 cycles.
